// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: one bit per cycle into HI/LO, with MTHI/MTLO writes.
// Multiply is shift-add on magnitudes; divide is restoring on magnitudes; signs applied at finish.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic                 dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift, div_diff;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem_fix;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    dbz_pend_d = dbz_pend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;

    abs_a     = (!op[0] && a[WIDTH-1]) ? -a : a;
    abs_b     = (!op[0] && b[WIDTH-1]) ? -b : b;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    // Remainder is one bit wider so the borrow of the trial subtraction survives.
    div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    prod      = neg_q ? -acc_q : acc_q;
    quo       = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    unique case (state_q)
      StIdle: begin
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start) begin
          state_d    = StRun;
          op_d       = op;
          cnt_d      = '0;
          dbz_d      = 1'b0;
          dbz_pend_d = op[1] && (b == '0);
          neg_d      = !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d     = !op[0] && a[WIDTH-1];
          // Low half holds the multiplier (multiply) or the dividend (divide).
          acc_d      = {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
          mcand_d    = op[1] ? abs_b : abs_a;
          rem_d      = '0;
        end
      end
      StRun: begin
        if (op_q[1]) begin
          if (!div_diff[WIDTH]) begin
            rem_d              = div_diff;
            acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d              = div_shift;
            acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFinish;
      end
      StFinish: begin
        state_d = StIdle;
        done_d  = 1'b1;
        dbz_d   = dbz_pend_q;
        if (op_q[1]) begin
          hi_d = rem_fix;
          lo_d = dbz_pend_q ? '1 : quo;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= '0;
      cnt_q      <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      dbz_pend_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      dbz_pend_q <= dbz_pend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases plus random ops against an
// arithmetic reference model; a negedge monitor checks every done pulse.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   done_seen = 0;

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sp;
    longint unsigned up;
    int          sx, sy;
    e = '0;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      2'b00: begin
        sp = longint'(sx) * longint'(sy);
        e.hi = sp[63:32];
        e.lo = sp[31:0];
      end
      2'b01: begin
        up = {32'd0, x} * {32'd0, y};
        e.hi = up[63:32];
        e.lo = up[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          e.hi = x;
          e.lo = 32'hffff_ffff;
          e.dbz = 1'b1;
        end else if (o == 2'b11) begin
          e.lo = x / y;
          e.hi = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hffff_ffff) begin
          e.lo = 32'h8000_0000;
          e.hi = 32'd0;
        end else begin
          e.lo = sx / sy;
          e.hi = sx % sy;
        end
      end
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (hi=%h lo=%h)", hi, lo);
      end else begin
        e = exp_q.pop_front();
        check("result_hi", 64'(hi), 64'(e.hi));
        check("result_lo", 64'(lo), 64'(e.lo));
        check("result_dbz", 64'(div_by_zero), 64'(e.dbz));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1 with the unit idle; returns at posedge+1 in the done cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic wr_hi, input logic [31:0] wv, output int bc);
    int          lat;
    logic [31:0] hi0, lo0;
    hi0   = wr_hi ? wv : hi;
    lo0   = lo;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    mthi  = wr_hi;
    wdata = wv;
    exp_q.push_back(model(o, x, y));
    @(posedge clk); #1;
    start = 1'b0;
    mthi  = 1'b0;
    check("dbz_clear_at_accept", 64'(div_by_zero), 64'(0));
    if (wr_hi) check("mthi_with_start", 64'(hi), 64'(wv));
    lat = 0;
    bc  = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy) bc++;
      if (lat == 16) begin
        check("hi_hold_busy", 64'(hi), 64'(hi0));
        check("lo_hold_busy", 64'(lo), 64'(lo0));
      end
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(33));
    check("busy_low_at_done", 64'(busy), 64'(0));
  endtask

  initial begin
    int          bc, d0;
    logic [31:0] x, y, lo0;
    logic [1:0]  o;
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_dbz", 64'(div_by_zero), 64'(0));
    reset = 1'b0;

    do_op(2'b01, 32'hffff_ffff, 32'hffff_ffff, 1'b0, 32'd0, bc);
    check("busy_cycles", 64'(bc), 64'(33));
    do_op(2'b00, 32'hffff_fffd, 32'd5, 1'b0, 32'd0, bc);
    do_op(2'b10, 32'hffff_fff9, 32'd2, 1'b0, 32'd0, bc);
    do_op(2'b10, 32'h8000_0000, 32'hffff_ffff, 1'b0, 32'd0, bc);
    do_op(2'b11, 32'd100, 32'd0, 1'b0, 32'd0, bc);
    check("dbz_in_done_cycle", 64'(div_by_zero), 64'(1));
    do_op(2'b01, 32'd2, 32'd3, 1'b0, 32'd0, bc);
    do_op(2'b10, 32'h8000_0000, 32'd0, 1'b0, 32'd0, bc);
    do_op(2'b01, 32'd4, 32'd5, 1'b1, 32'hcafe_f00d, bc);

    // MTHI, then writes and start while busy must be ignored.
    @(posedge clk); #1;
    mthi = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1;
    mthi = 1'b0;
    check("mthi_latency", 64'(hi), 64'(32'h1234));
    lo0 = lo;
    start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
    exp_q.push_back(model(2'b01, 32'd2, 32'd3));
    d0 = done_seen;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mthi = 1'b1; mtlo = 1'b1; start = 1'b1; wdata = 32'hdead_beef;
    op = 2'b00; a = 32'd5; b = 32'd7;
    repeat (4) @(posedge clk);
    #1;
    check("busy_hi_ignores_mthi", 64'(hi), 64'(32'h1234));
    check("busy_lo_ignores_mtlo", 64'(lo), 64'(lo0));
    mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    check("single_done_after_busy_start", 64'(done_seen - d0), 64'(1));

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 15));
        2: begin x = 32'h8000_0000; y = 32'hffff_ffff; end
        3: x = 32'($urandom_range(0, 100));
        default: ;
      endcase
      do_op(o, x, y, 1'b0, 32'd0, bc);
    end

    // Reset in the middle of a divide aborts it with no done.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    d0 = done_seen;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_dbz", 64'(div_by_zero), 64'(0));
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_seen - d0), 64'(0));
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
